// File: rtl/led_sequencer_if.sv
// Control and status bundle between the board-level LED controller and the
// LED sequencer: pattern controls in, registered LED pattern and step tick out.
interface led_sequencer_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [1:0]       speed;
    logic             step;
    logic [WIDTH-1:0] leds;
    logic             tick;

    modport master (
        output en, mode, dir, speed, step,
        input  leds, tick
    );

    modport slave (
        input  en, mode, dir, speed, step,
        output leds, tick
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: a free-running prescaler produces a step tick that
// advances a WIDTH-bit Johnson / rotate / bounce / binary-count pattern.
module led_sequencer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned PRESCALE_BITS = 23
) (
    input  logic            clk,
    input  logic            rst,
    led_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_COUNT   = 2'd3
    } mode_e;

    mode_e                    mode_q;
    mode_e                    mode_in;
    logic [WIDTH-1:0]         leds_q;
    logic [WIDTH-1:0]         next_leds;
    logic                     bounce_left;
    logic                     next_bounce_left;
    logic [PRESCALE_BITS-1:0] count;
    logic [PRESCALE_BITS-1:0] period_m1;
    logic                     period_done;
    logic                     advance;
    logic                     mode_changed;
    logic                     tick_q;

    function automatic logic [WIDTH-1:0] seed(input mode_e m);
        return (m == MODE_COUNT) ? '0 : WIDTH'(1);
    endfunction

    assign mode_in      = mode_e'(bus.mode);
    assign mode_changed = (mode_in != mode_q);

    // T-1 = 2^(PRESCALE_BITS-speed) - 1, i.e. an all-ones mask shortened by speed.
    assign period_m1   = {PRESCALE_BITS{1'b1}} >> bus.speed;
    // >= rather than == so that shortening the period mid-count fires at once.
    assign period_done = (count >= period_m1);
    assign advance     = (period_done && bus.en) || bus.step;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_leds        = leds_q;
        next_bounce_left = bounce_left;
        case (mode_q)
            MODE_JOHNSON: begin
                if (bus.dir) next_leds = {leds_q[WIDTH-2:0], ~leds_q[WIDTH-1]};
                else         next_leds = {~leds_q[0], leds_q[WIDTH-1:1]};
            end
            MODE_ROTATE: begin
                if (bus.dir) next_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                else         next_leds = {leds_q[0], leds_q[WIDTH-1:1]};
            end
            MODE_BOUNCE: begin
                // Reverse on the step that lands on an end so each end shows once.
                next_leds = bounce_left ? (leds_q << 1) : (leds_q >> 1);
                if (next_leds[WIDTH-1])  next_bounce_left = 1'b0;
                else if (next_leds[0])   next_bounce_left = 1'b1;
            end
            MODE_COUNT: begin
                if (bus.dir) next_leds = leds_q - WIDTH'(1);
                else         next_leds = leds_q + WIDTH'(1);
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            tick_q      <= 1'b0;
            mode_q      <= mode_in;
            leds_q      <= seed(mode_in);
            bounce_left <= 1'b1;
        end else if (mode_changed) begin
            // A mode switch reseeds the pattern and swallows any coincident advance.
            count       <= '0;
            tick_q      <= 1'b0;
            mode_q      <= mode_in;
            leds_q      <= seed(mode_in);
            bounce_left <= 1'b1;
        end else begin
            if (bus.step)                   count <= '0;
            else if (bus.en && period_done) count <= '0;
            else if (bus.en)                count <= count + PRESCALE_BITS'(1);

            tick_q <= advance;
            if (advance) begin
                leds_q      <= next_leds;
                bounce_left <= next_bounce_left;
            end
        end
    end

    assign bus.leds = leds_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with WIDTH=4, PRESCALE_BITS=4.
module tb_led_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PB    = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    led_sequencer_if #(.WIDTH(WIDTH)) bus ();

    led_sequencer #(.WIDTH(WIDTH), .PRESCALE_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        cycles(1);
        bus.step = 1'b0;
    endtask

    // Returns the number of edges until tick is seen; 200 means it never came.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!bus.tick && n < 200);
    endtask

    logic [WIDTH-1:0] johnson_seq [8];
    logic [WIDTH-1:0] bounce_seq  [7];
    int               n;

    initial begin
        johnson_seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                        4'b1111, 4'b0111, 4'b0011, 4'b0001};
        bounce_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                        4'b0010, 4'b0001, 4'b0010};

        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.mode  = 2'd0;
        bus.dir   = 1'b0;
        bus.speed = 2'd0;
        bus.step  = 1'b0;
        cycles(1);
        rst = 1'b0;
        check("reset_leds", 32'(bus.leds), 32'b0001);
        check("reset_tick", 32'(bus.tick), 32'd0);

        // Johnson, slowest speed: one advance every 16 clocks.
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_tick(n);
            check($sformatf("johnson_interval_%0d", i), 32'(n), 32'd16);
            check($sformatf("johnson_leds_%0d", i), 32'(bus.leds), 32'(johnson_seq[i]));
        end
        cycles(1);
        check("tick_one_cycle", 32'(bus.tick), 32'd0);

        // Speed 0 -> 3 with count at 10: tick on the very next edge, then every 2.
        cycles(9);
        bus.speed = 2'd3;
        wait_tick(n);
        check("speedup_first", 32'(n), 32'd1);
        check("speedup_leds0", 32'(bus.leds), 32'b0000);
        wait_tick(n);
        check("speedup_period", 32'(n), 32'd2);
        check("speedup_leds1", 32'(bus.leds), 32'b1000);
        wait_tick(n);
        check("speedup_period2", 32'(n), 32'd2);
        check("speedup_leds2", 32'(bus.leds), 32'b1100);

        // Pause at count 7 for 40 cycles, then 9 cycles to the next tick.
        bus.speed = 2'd0;
        cycles(7);
        bus.en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            check("pause_tick", 32'(bus.tick), 32'd0);
        end
        check("pause_leds", 32'(bus.leds), 32'b1100);
        bus.en = 1'b1;
        wait_tick(n);
        check("resume_interval", 32'(n), 32'd9);
        check("resume_leds", 32'(bus.leds), 32'b1110);

        // Manual step with en=0, Johnson left.
        bus.en  = 1'b0;
        bus.dir = 1'b1;
        do_step();
        check("step_tick", 32'(bus.tick), 32'd1);
        check("step_johnson_left", 32'(bus.leds), 32'b1100);
        cycles(1);
        check("step_tick_clear", 32'(bus.tick), 32'd0);

        // Step coincident with a prescaler tick: single advance, count cleared.
        bus.dir   = 1'b0;
        bus.speed = 2'd3;
        bus.en    = 1'b1;
        cycles(1);
        check("pre_coincide_tick", 32'(bus.tick), 32'd0);
        do_step();
        check("coincide_tick", 32'(bus.tick), 32'd1);
        check("coincide_leds", 32'(bus.leds), 32'b1110);
        wait_tick(n);
        check("coincide_next_interval", 32'(n), 32'd2);
        check("coincide_next_leds", 32'(bus.leds), 32'b1111);
        bus.en = 1'b0;

        // Bounce via steps only; dir is ignored.
        bus.mode = 2'd2;
        cycles(1);
        check("bounce_seed", 32'(bus.leds), 32'b0001);
        check("bounce_seed_tick", 32'(bus.tick), 32'd0);
        for (int i = 0; i < 7; i++) begin
            bus.dir = i[0];
            do_step();
            check($sformatf("bounce_tick_%0d", i), 32'(bus.tick), 32'd1);
            check($sformatf("bounce_leds_%0d", i), 32'(bus.leds), 32'(bounce_seq[i]));
            cycles(2);
            check($sformatf("bounce_idle_%0d", i), 32'(bus.tick), 32'd0);
        end

        // Count down from reset, then a mode change that swallows a step.
        bus.mode = 2'd3;
        bus.dir  = 1'b1;
        rst      = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("count_seed", 32'(bus.leds), 32'b0000);
        do_step();
        check("count_wrap_down", 32'(bus.leds), 32'b1111);
        do_step();
        check("count_down", 32'(bus.leds), 32'b1110);
        bus.mode = 2'd1;
        do_step();
        check("modechg_leds", 32'(bus.leds), 32'b0001);
        check("modechg_tick", 32'(bus.tick), 32'd0);
        bus.dir = 1'b0;
        do_step();
        check("rotate_right0", 32'(bus.leds), 32'b1000);
        do_step();
        check("rotate_right1", 32'(bus.leds), 32'b0100);
        bus.dir = 1'b1;
        do_step();
        check("rotate_left", 32'(bus.leds), 32'b1000);

        // Reset mid-period in mode 3 clears pattern, tick and count.
        bus.dir   = 1'b0;
        bus.speed = 2'd0;
        bus.en    = 1'b1;
        cycles(5);
        bus.mode = 2'd3;
        rst      = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midreset_leds", 32'(bus.leds), 32'b0000);
        check("midreset_tick", 32'(bus.tick), 32'd0);
        wait_tick(n);
        check("midreset_interval", 32'(n), 32'd16);
        check("midreset_count_up", 32'(bus.leds), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
